// File: rtl/fnd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fnd_pkg                                                |
// | Description : Shared register offsets, control-bit indices and APB   |
// |               handshake states for the FND control register block.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fnd_pkg;

   // Byte offsets of the word-aligned registers
   localparam logic [3:0] FCR_OFS = 4'h0;
   localparam logic [3:0] FDR_OFS = 4'h4;
   localparam logic [3:0] FSR_OFS = 4'h8;

   // Word indices (paddr[3:2]) derived from the byte offsets
   localparam logic [1:0] FCR_IDX = FCR_OFS[3:2];
   localparam logic [1:0] FDR_IDX = FDR_OFS[3:2];
   localparam logic [1:0] FSR_IDX = FSR_OFS[3:2];

   // FCR bit positions
   localparam int EN_BIT    = 0;
   localparam int BLINK_BIT = 1;

   // APB handshake states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } apb_state_t;

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/fnd_blink_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fnd_blink_timer                                        |
// | Description : Free-running half-period counter that toggles a blink  |
// |               phase while run is high; counter and phase are held at |
// |               zero otherwise so blinking always starts visible.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fnd_blink_timer #(
   parameter int BLINK_HALF = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic phase
);

   // A one-bit counter is kept even for degenerate half-periods of 1
   localparam int              c_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLINK_HALF - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_phase;

   // Count half-periods while running; clear everything when stopped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (!run) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_cnt == c_LAST) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign phase = r_phase;

endmodule : fnd_blink_timer
`default_nettype wire

// File: rtl/apb_fnd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_fnd_ctrl                                           |
// | Description : APB slave holding the FND display value, enable/blink  |
// |               control and a sticky overflow flag. Every transfer     |
// |               takes one wait state; writes land on the pready edge.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb_fnd_ctrl
   import fnd_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int BLINK_HALF = 50_000_000,
   parameter int MAX_VAL    = 9999
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic [15:0]       fnd_value,
   output logic              fnd_blank
);

   localparam logic [15:0] c_MAX_VAL = 16'(MAX_VAL);

   apb_state_t  r_state;
   apb_state_t  w_next;

   logic        r_en;
   logic        r_blink;
   logic [15:0] r_fdr;
   logic        r_ovf;
   logic [31:0] r_prdata;

   logic        w_access;
   logic [1:0]  w_idx;
   logic        w_wr_fcr;
   logic        w_wr_fdr;
   logic        w_wr_fsr;
   logic        w_over;
   logic [31:0] w_rdata;
   logic        w_phase;
   logic        w_unused_ok;

   // Upper write-data bits and the byte-lane address bits carry no meaning here
   assign w_unused_ok = ^{pwdata[31:16], paddr};

   // Register access happens on the WAIT->DONE edge, and only if the master kept psel
   assign w_access = (r_state == WAIT) && psel;
   assign w_idx    = paddr[3:2];
   assign w_wr_fcr = w_access && pwrite && (w_idx == FCR_IDX);
   assign w_wr_fdr = w_access && pwrite && (w_idx == FDR_IDX);
   assign w_wr_fsr = w_access && pwrite && (w_idx == FSR_IDX);
   assign w_over   = pwdata[15:0] > c_MAX_VAL;

   // APB state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // APB next-state: one wait cycle, one pready cycle, abort if psel drops in WAIT
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (psel && penable) w_next = WAIT;
         WAIT:    w_next = psel ? DONE : IDLE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Read-data mux; the reserved slot and unused bits read as zero
   always_comb begin
      w_rdata = '0;
      case (w_idx)
         FCR_IDX: begin
            w_rdata[EN_BIT]    = r_en;
            w_rdata[BLINK_BIT] = r_blink;
         end
         FDR_IDX: w_rdata[15:0] = r_fdr;
         FSR_IDX: w_rdata[0]    = r_ovf;
         default: w_rdata       = '0;
      endcase
   end

   // Control, data and status registers plus the captured read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en     <= 1'b0;
         r_blink  <= 1'b0;
         r_fdr    <= '0;
         r_ovf    <= 1'b0;
         r_prdata <= '0;
      end else begin
         if (w_wr_fcr) begin
            r_en    <= pwdata[EN_BIT];
            r_blink <= pwdata[BLINK_BIT];
         end
         // Out-of-range values saturate and latch the overflow flag
         if (w_wr_fdr) begin
            if (w_over) begin
               r_fdr <= c_MAX_VAL;
               r_ovf <= 1'b1;
            end else begin
               r_fdr <= pwdata[15:0];
            end
         end
         // Only one transfer is in flight, so set and clear never collide
         if (w_wr_fsr && pwdata[0]) r_ovf <= 1'b0;
         if (w_access && !pwrite)   r_prdata <= w_rdata;
      end
   end

   fnd_blink_timer #(
      .BLINK_HALF (BLINK_HALF)
   ) u_blink (
      .clk   (clk),
      .reset (reset),
      .run   (r_en && r_blink),
      .phase (w_phase)
   );

   assign prdata    = r_prdata;
   assign pready    = (r_state == DONE);
   assign fnd_value = r_fdr;
   assign fnd_blank = !r_en || (r_blink && w_phase);

endmodule : apb_fnd_ctrl
`default_nettype wire

// File: tb/tb_apb_fnd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_apb_fnd_ctrl                                        |
// | Description : Self-checking bench for apb_fnd_ctrl: directed vector  |
// |               table, blink/abort/reset sequences and randomized APB  |
// |               traffic against a register-level reference model.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_apb_fnd_ctrl;

   localparam int ADDR_W     = 4;
   localparam int BLINK_HALF = 8;
   localparam int MAX_VAL    = 9999;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic [15:0] fnd_value;
   logic        fnd_blank;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [15:0] exp_val;
      logic        exp_blank;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] rd;
   logic [31:0] last_rd;
   int          lat;
   logic        saw;

   // Reference model state
   int m_en, m_fdr, m_ovf;

   apb_fnd_ctrl #(
      .ADDR_W     (ADDR_W),
      .BLINK_HALF (BLINK_HALF),
      .MAX_VAL    (MAX_VAL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .fnd_value (fnd_value),
      .fnd_blank (fnd_blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Full APB transfer; returns at the negedge where pready is seen
   task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdo, output int lato);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(negedge clk);
      penable = 1'b1;
      lato = 0;
      do begin
         @(negedge clk);
         lato++;
      end while (!pready && lato < 8);
      rdo = prdata;
      psel = 1'b0; penable = 1'b0;
   endtask

   function automatic int model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return m_en;
         2'd1:    return m_fdr;
         2'd2:    return m_ovf;
         default: return 0;
      endcase
   endfunction

   task automatic model_write(input logic [3:0] a, input logic [31:0] d);
      int v;
      case (a[3:2])
         2'd0: m_en = int'(d & 32'h1);
         2'd1: begin
            v = int'(d & 32'hFFFF);
            if (v > MAX_VAL) begin m_fdr = MAX_VAL; m_ovf = 1; end
            else m_fdr = v;
         end
         2'd2: if ((d & 32'h1) != 0) m_ovf = 0;
         default: ;
      endcase
   endtask

   initial begin
      reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("rst_pready_low", {31'b0, pready}, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", {31'b0, pready}, 32'h0);
      chk("rst_value", {16'b0, fnd_value}, 32'h0);
      chk("rst_blank", {31'b0, fnd_blank}, 32'h1);

      // ---------------- directed vector table ----------------
      vq.push_back('{1'b0, 4'h0, 32'h0,          32'h0,  16'd0,    1'b1});
      vq.push_back('{1'b0, 4'h4, 32'h0,          32'h0,  16'd0,    1'b1});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h0,  16'd0,    1'b1});
      vq.push_back('{1'b1, 4'h0, 32'h1,          32'h0,  16'd0,    1'b0});
      vq.push_back('{1'b1, 4'h4, 32'd1234,       32'h0,  16'd1234, 1'b0});
      vq.push_back('{1'b0, 4'h4, 32'h0,          32'd1234, 16'd1234, 1'b0});
      vq.push_back('{1'b0, 4'h0, 32'h0,          32'h1,  16'd1234, 1'b0});
      vq.push_back('{1'b1, 4'h4, 32'h3000,       32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h4, 32'h0,          32'd9999, 16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h1,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'h8, 32'h0,          32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h1,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'h8, 32'h1,          32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'h4, 32'hABCD_0001,  32'h0,  16'd1,    1'b0});
      vq.push_back('{1'b1, 4'h4, 32'hABCD_270F,  32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'h4, 32'h0000_2710,  32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'h8, 32'h0,          32'h1,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'hC, 32'hFFFF_FFFF,  32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b0, 4'hC, 32'h0,          32'h0,  16'd9999, 1'b0});
      vq.push_back('{1'b1, 4'h0, 32'hFFFF_FFFC,  32'h0,  16'd9999, 1'b1});
      vq.push_back('{1'b0, 4'h0, 32'h0,          32'h0,  16'd9999, 1'b1});

      last_rd = 32'h0;
      foreach (vq[i]) begin
         apb_xfer(vq[i].wr, vq[i].addr, vq[i].wdata, rd, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_value", i), {16'b0, fnd_value}, {16'b0, vq[i].exp_val});
         chk($sformatf("vec%0d_blank", i), {31'b0, fnd_blank}, {31'b0, vq[i].exp_blank});
         if (!vq[i].wr) begin
            chk($sformatf("vec%0d_prdata", i), rd, vq[i].exp_rd);
            last_rd = vq[i].exp_rd;
         end else begin
            chk($sformatf("vec%0d_prdata_hold", i), rd, last_rd);
         end
      end

      // ---------------- blink sequence ----------------
      apb_xfer(1'b1, 4'h0, 32'h3, rd, lat);
      for (int k = 0; k < 24; k++) begin
         chk($sformatf("blink_k%0d", k), {31'b0, fnd_blank}, {31'b0, logic'(((k / BLINK_HALF) % 2) == 1)});
         @(negedge clk);
      end
      chk("blink_mid_blank", {31'b0, fnd_blank}, 32'h1);
      apb_xfer(1'b1, 4'h0, 32'h1, rd, lat);
      chk("blink_off_visible", {31'b0, fnd_blank}, 32'h0);
      @(negedge clk);
      chk("blink_off_stays", {31'b0, fnd_blank}, 32'h0);

      // ---------------- psel dropped during WAIT ----------------
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'd55;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (pready) saw = 1'b1;
      end
      chk("abort_no_pready", {31'b0, saw}, 32'h0);
      chk("abort_value", {16'b0, fnd_value}, 32'd9999);
      apb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
      chk("abort_fdr_read", rd, 32'd9999);

      // ---------------- reset during WAIT ----------------
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'd77;
      @(negedge clk);
      penable = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_pready", {31'b0, pready}, 32'h0);
      chk("midrst_value", {16'b0, fnd_value}, 32'h0);
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (pready) saw = 1'b1;
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (pready) saw = 1'b1;
      end
      chk("midrst_no_pready", {31'b0, saw}, 32'h0);
      chk("midrst_blank", {31'b0, fnd_blank}, 32'h1);
      apb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
      chk("midrst_fdr_read", rd, 32'h0);

      // ---------------- randomized traffic vs. model ----------------
      m_en = 0; m_fdr = 0; m_ovf = 0;
      last_rd = rd;
      for (int n = 0; n < 80; n++) begin
         logic        wr;
         logic [3:0]  a;
         logic [31:0] d;
         int          exp_rd;
         wr = logic'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 3) << 2);
         case ($urandom_range(0, 3))
            0:       d = $urandom;
            1:       d = 32'($urandom_range(0, MAX_VAL));
            2:       d = 32'($urandom_range(MAX_VAL - 1, MAX_VAL + 2));
            default: d = {16'($urandom), 16'($urandom_range(0, 12000))};
         endcase
         if (a == 4'h0) d = d & ~32'h2;
         exp_rd = model_read(a);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         apb_xfer(wr, a, d, rd, lat);
         if (wr) model_write(a, d);
         chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
         if (!wr) begin
            chk($sformatf("rnd%0d_prdata", n), rd, 32'(exp_rd));
            last_rd = 32'(exp_rd);
         end else begin
            chk($sformatf("rnd%0d_prdata_hold", n), rd, last_rd);
         end
         chk($sformatf("rnd%0d_value", n), {16'b0, fnd_value}, 32'(m_fdr));
         chk($sformatf("rnd%0d_blank", n), {31'b0, fnd_blank}, 32'(m_en == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      n_checks++;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_apb_fnd_ctrl
`default_nettype wire
